// File: rtl/inst_queue_if.sv
// Avalon-MM slave and control-unit issue signals of the instruction queue.
// The DUT uses the slave modport; the host/control-unit side uses the master modport.
interface inst_queue_if;
    logic [1:0]  avs_address;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic        avs_read;
    logic [31:0] avs_readdata;
    logic [31:0] h2f_io;
    logic        h2f_write;
    logic        ctrl_done;
    logic        busy;

    modport slave (
        input  avs_address, avs_write, avs_writedata, avs_read, ctrl_done,
        output avs_readdata, h2f_io, h2f_write, busy
    );

    modport master (
        output avs_address, avs_write, avs_writedata, avs_read, ctrl_done,
        input  avs_readdata, h2f_io, h2f_write, busy
    );
endinterface

// File: rtl/inst_queue.sv
// Host-side instruction FIFO. Instructions are issued one at a time to the NPU control unit,
// and each issued word is held until the control unit has finished with it.
module inst_queue #(
    parameter int unsigned DEPTH = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    inst_queue_if.slave  bus
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam int unsigned PTR_W = $clog2(DEPTH);

    typedef enum logic [1:0] {StIdle, StIssue, StWaitAck, StWaitDone} state_e;

    state_e            state_q, state_d;
    logic [31:0]       mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              ovf_q, ovf_d;
    logic [31:0]       issued_q, issued_d;
    logic [31:0]       h2f_io_q, h2f_io_d;
    logic [31:0]       rdata_q, rdata_d;

    logic empty, full, busy;
    logic push_req, ctrl_wr, flush, clr_ovf;
    logic pop, push_ok, ovf_set;
    logic [31:0] status;

    assign empty    = (count_q == '0);
    assign full     = (count_q == CNT_W'(DEPTH));
    assign busy     = !empty || (state_q != StIdle);

    assign push_req = bus.avs_write && (bus.avs_address == 2'd0);
    assign ctrl_wr  = bus.avs_write && (bus.avs_address == 2'd2);
    assign flush    = ctrl_wr && bus.avs_writedata[0];
    assign clr_ovf  = ctrl_wr && bus.avs_writedata[1];

    // A pop frees a slot in the same cycle, so a full FIFO still accepts a push then.
    assign push_ok  = push_req && !flush && (!full || pop);
    assign ovf_set  = push_req && !flush && full && !pop;

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            StIdle: begin
                if (!empty && bus.ctrl_done && !flush) begin
                    pop     = 1'b1;
                    state_d = StIssue;
                end
            end
            StIssue:    state_d = StWaitAck;
            StWaitAck:  if (!bus.ctrl_done) state_d = StWaitDone;
            StWaitDone: if (bus.ctrl_done) state_d = StIdle;
            default:    state_d = StIdle;
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)     rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (push_ok && !pop)      count_d = count_q + CNT_W'(1);
            else if (!push_ok && pop) count_d = count_q - CNT_W'(1);
        end
    end

    always_comb begin
        ovf_d    = ovf_set ? 1'b1 : (clr_ovf ? 1'b0 : ovf_q);
        issued_d = (state_q == StIssue) ? issued_q + 32'd1 : issued_q;
        h2f_io_d = pop ? mem_q[rd_ptr_q] : h2f_io_q;
    end

    always_comb begin
        status              = '0;
        status[31]          = ovf_q;
        status[30]          = busy;
        status[29]          = full;
        status[28]          = empty;
        status[CNT_W-1:0]   = count_q;
    end

    always_comb begin
        rdata_d = rdata_q;
        if (bus.avs_read) begin
            case (bus.avs_address)
                2'd1:    rdata_d = status;
                2'd3:    rdata_d = issued_q;
                default: rdata_d = '0;
            endcase
        end
    end

    // Storage has no reset; only the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= bus.avs_writedata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            issued_q <= '0;
            h2f_io_q <= '0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            issued_q <= issued_d;
            h2f_io_q <= h2f_io_d;
            rdata_q  <= rdata_d;
        end
    end

    assign bus.avs_readdata = rdata_q;
    assign bus.h2f_io       = h2f_io_q;
    assign bus.h2f_write    = (state_q == StIssue);
    assign bus.busy         = busy;

endmodule

// File: tb/tb_inst_queue.sv
// Bench for inst_queue: directed scenarios plus random traffic, compared every cycle against a
// queue-based model and a simple 3-state control-unit responder.
module tb_inst_queue;
    localparam int unsigned DEPTH = 16;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    inst_queue_if bus ();

    inst_queue #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference model: the queue contents plus the life cycle of the word in flight.
    logic [31:0] m_q[$];
    bit          m_ovf;
    logic [31:0] m_issued, m_cur, m_rdata;
    bit          m_strobe, m_need_low, m_need_high;

    // Control-unit responder: 0 idle, 1 decode, 2 execute (stretched while c_stall).
    int c_st;
    bit c_hold, c_stall;

    int          cyc;
    int          s_cyc[$];
    logic [31:0] s_data[$];

    function automatic bit m_busy();
        return (m_q.size() != 0) || m_strobe || m_need_low || m_need_high;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_ovf = 0; m_issued = 0; m_cur = 0; m_rdata = 0;
        m_strobe = 0; m_need_low = 0; m_need_high = 0;
    endtask

    task automatic model_edge(input logic [1:0] a, input bit w, input logic [31:0] wd,
                              input bit r, input bit done);
        int n;
        bit empty, full, flush, clr, push, pop, set_ovf;
        n     = m_q.size();
        empty = (n == 0);
        full  = (n == DEPTH);
        flush = w && (a == 2'd2) && wd[0];
        clr   = w && (a == 2'd2) && wd[1];
        push  = w && (a == 2'd0);
        if (r) begin
            case (a)
                2'd1:    m_rdata = {m_ovf, m_busy(), full, empty, 28'(n)};
                2'd3:    m_rdata = m_issued;
                default: m_rdata = 32'd0;
            endcase
        end
        pop = !(m_strobe || m_need_low || m_need_high) && !empty && done && !flush;
        if (m_strobe) begin
            m_issued++;
            m_need_low = 1;
        end else if (m_need_low && !done) begin
            m_need_low  = 0;
            m_need_high = 1;
        end else if (m_need_high && done) begin
            m_need_high = 0;
        end
        m_strobe = pop;
        if (pop) m_cur = m_q.pop_front();
        set_ovf = 0;
        if (flush) m_q.delete();
        else if (push) begin
            if (m_q.size() < DEPTH) m_q.push_back(wd);
            else set_ovf = 1;
        end
        if (set_ovf) m_ovf = 1;
        else if (clr) m_ovf = 0;
    endtask

    // Entered and left at a falling edge: check outputs, drive inputs, advance one clock.
    task automatic step(input logic [1:0] a, input bit w, input logic [31:0] wd, input bit r);
        bit saw;
        check_eq("h2f_write", 32'(bus.h2f_write), 32'(m_strobe));
        check_eq("h2f_io", bus.h2f_io, m_cur);
        check_eq("busy", 32'(bus.busy), 32'(m_busy()));
        check_eq("readdata", bus.avs_readdata, m_rdata);
        saw = bus.h2f_write;
        if (saw) begin
            s_cyc.push_back(cyc);
            s_data.push_back(bus.h2f_io);
        end
        bus.avs_address   = a;
        bus.avs_write     = w;
        bus.avs_writedata = wd;
        bus.avs_read      = r;
        bus.ctrl_done     = (c_st == 0) && !c_hold;
        @(posedge clk);
        model_edge(a, w, wd, r, bus.ctrl_done);
        case (c_st)
            0:       if (saw) c_st = 1;
            1:       c_st = 2;
            default: if (!c_stall) c_st = 0;
        endcase
        cyc++;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) step(2'd0, 1'b0, 32'd0, 1'b0);
    endtask

    task automatic push(input logic [31:0] d);
        step(2'd0, 1'b1, d, 1'b0);
    endtask

    task automatic rd_chk(input logic [1:0] a, input logic [31:0] exp, input string tag);
        step(a, 1'b0, 32'd0, 1'b1);
        check_eq(tag, bus.avs_readdata, exp);
    endtask

    task automatic clear_log();
        s_cyc.delete();
        s_data.delete();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.avs_address = 0; bus.avs_write = 0; bus.avs_writedata = 0; bus.avs_read = 0;
        c_st = 0; c_hold = 0; c_stall = 0;
        bus.ctrl_done = 1'b1;
        model_reset();
        #1;
        check_eq("rst_h2f_write", 32'(bus.h2f_write), 32'd0);
        check_eq("rst_h2f_io", bus.h2f_io, 32'd0);
        check_eq("rst_busy", 32'(bus.busy), 32'd0);
        check_eq("rst_readdata", bus.avs_readdata, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        cyc = 0;
        do_reset();
        rd_chk(2'd1, 32'h1000_0000, "status_reset");
        rd_chk(2'd3, 32'd0, "issued_reset");

        // Single issue latency
        clear_log();
        base = cyc;
        push(32'h8000_1234);
        idle(8);
        check_eq("single_count", s_cyc.size(), 1);
        if (s_cyc.size() > 0) begin
            check_eq("single_latency", s_cyc[0] - base, 2);
            check_eq("single_data", s_data[0], 32'h8000_1234);
        end
        rd_chk(2'd3, 32'd1, "issued_single");

        // Back-to-back burst: one issue every 5 cycles
        clear_log();
        base = cyc;
        push(32'hA); push(32'hB); push(32'hC);
        idle(20);
        check_eq("burst_count", s_cyc.size(), 3);
        for (int i = 0; i < s_cyc.size() && i < 3; i++) begin
            check_eq("burst_cycle", s_cyc[i] - base, 2 + 5 * i);
            check_eq("burst_data", s_data[i], 32'hA + i);
        end
        rd_chk(2'd1, 32'h1000_0000, "status_burst_done");

        // Overflow: 17 pushes with the control unit held busy
        c_hold = 1;
        for (int i = 0; i < 17; i++) push(i);
        rd_chk(2'd1, 32'hE000_0010, "status_overflow");
        clear_log();
        c_hold = 0;
        idle(90);
        check_eq("ovf_issue_count", s_cyc.size(), 16);
        for (int i = 0; i < s_data.size() && i < 16; i++) check_eq("ovf_data", s_data[i], i);
        rd_chk(2'd1, 32'h9000_0000, "status_ovf_sticky");
        step(2'd2, 1'b1, 32'h2, 1'b0);
        rd_chk(2'd1, 32'h1000_0000, "status_ovf_clear");

        // Push to a full FIFO in the same cycle as a pop
        c_hold = 1;
        for (int i = 0; i < 16; i++) push(32'd100 + i);
        clear_log();
        c_hold = 0;
        push(32'd200);
        rd_chk(2'd1, 32'h6000_0010, "status_pushpop");
        idle(95);
        check_eq("pushpop_count", s_cyc.size(), 17);
        if (s_data.size() == 17) check_eq("pushpop_last", s_data[16], 32'd200);

        // Flush while the first of five is in flight
        c_hold = 1;
        for (int i = 0; i < 5; i++) push(32'd300 + i);
        clear_log();
        c_hold = 0;
        c_stall = 1;
        idle(6);
        step(2'd2, 1'b1, 32'h1, 1'b0);
        rd_chk(2'd1, 32'h5000_0000, "status_flush");
        idle(5);
        c_stall = 0;
        idle(10);
        check_eq("flush_issue_count", s_cyc.size(), 1);
        check_eq("flush_io_hold", bus.h2f_io, 32'd300);
        check_eq("flush_busy", 32'(bus.busy), 32'd0);

        // Reset in the middle of an in-flight instruction with three queued
        c_hold = 1;
        for (int i = 0; i < 4; i++) push(32'd400 + i);
        c_hold = 0;
        c_stall = 1;
        idle(6);
        do_reset();
        rd_chk(2'd1, 32'h1000_0000, "status_after_rst");
        rd_chk(2'd3, 32'd0, "issued_after_rst");

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            int op;
            if ($urandom_range(0, 59) == 0) c_hold = !c_hold;
            c_stall = ($urandom_range(0, 3) == 0);
            op = $urandom_range(0, 99);
            if (op < 35)      push($urandom);
            else if (op < 37) step(2'd2, 1'b1, 32'h2, 1'b0);
            else if (op < 38) step(2'd2, 1'b1, 32'($urandom_range(0, 3)), 1'b0);
            else if (op < 40) step($urandom_range(0, 1) ? 2'd1 : 2'd3, 1'b1, $urandom, 1'b0);
            else if (op < 70) step(2'($urandom_range(0, 3)), 1'b0, 32'd0, 1'b1);
            else              idle(1);
        end
        c_hold = 0;
        c_stall = 0;
        idle(120);
        rd_chk(2'd3, m_issued, "issued_random");
        check_eq("busy_random_end", 32'(bus.busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
